cfg_chain_loader: RTL and testbench
===================================

Name: cfg_chain_loader

Overview:
- Upstream stage of the switch-box configuration chain.
- Accepts configuration words from the host/config-memory side over a valid/ready interface and serialises them MSB-first onto the daisy-chained switch shift chain.
- Generates the chain's shift_clk, shift_en and shift_i, and observes the chain tail (shift_o of the last switch).
- Holds shift_en high, with all pass-gates off, until a complete bitstream has been shifted in.

Parameters:
- NUM_TILES, 4, number of switch boxes daisy-chained.
- BITS_PER_TILE, 40, configuration bits per switch box.
- WORD_W, 8, width of the input configuration word.
- TOTAL_BITS, NUM_TILES*BITS_PER_TILE, total chain length (derived, not overridden).

Ports:
- clk  input  1  system clock. One clock domain.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a pass.
- verify  input  1  sampled with start. 1 = verify pass, 0 = plain load.
- cfg_data  input  WORD_W  configuration word, MSB shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- shift_clk  output  1  chain shift clock, registered.
- shift_en  output  1  chain shift enable, registered.
- shift_i  output  1  serial data into the first switch, registered.
- chain_tail  input  1  shift_o of the last switch in the chain.
- busy  output  1  pass in progress.
- done  output  1  one-cycle pulse at pass completion.
- cfg_loaded  output  1  chain holds a complete bitstream.
- mismatch  output  1  sticky verify-failure flag.

Behaviour:
- Reset values: shift_en=1, shift_clk=0, shift_i=0, cfg_ready=0, busy=0, done=0, cfg_loaded=0, mismatch=0. FSM returns to IDLE.
- Reset asserted mid-pass aborts the pass immediately. The chain is left partially loaded with shift_en=1, so the fabric stays disconnected. cfg_loaded=0.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, FINISH.
- IDLE:
  - start=1 latches verify into a mode register.
  - Clears the bit counter.
  - Clears mismatch only when verify=0.
  - Sets busy=1 and shift_en=1, clears cfg_loaded, then goes to FETCH.
  - start while busy=1 is ignored.
- FETCH:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready, loads the word into the shift register and sets the bit index to WORD_W-1, then goes to SHIFT_LO.
  - cfg_ready=0 in every other state.
- SHIFT_LO:
  - shift_clk=0.
  - shift_i = word[bit index].
  - In verify mode, if chain_tail != word[bit index], set mismatch. chain_tail is sampled here, before the rising edge.
  - Next state: SHIFT_HI.
- SHIFT_HI:
  - shift_clk=1, which gives the chain's rising edge. shift_i is held stable.
  - Bit counter increments.
  - If counter reaches TOTAL_BITS, go to FINISH.
  - Else if bit index = 0, go to FETCH.
  - Else decrement the index and go to SHIFT_LO.
- One chain bit therefore takes 2 clk cycles, plus 1 FETCH cycle per word when cfg_valid is already high.
- Partial last word: when TOTAL_BITS is not a multiple of WORD_W, the remaining low bits of the final word are discarded. No further words are requested.
- FINISH (one cycle):
  - shift_clk=0, shift_en=0, busy=0, done=1, cfg_loaded=1, then IDLE.
  - shift_en falls only after the final shift_clk falling edge.
- Verify semantics: the host re-sends the same bitstream. Bit k emerging at chain_tail equals bit k of the previous load, and the chain is rewritten with identical data.
- cfg_valid low in FETCH stalls indefinitely. shift_clk stays 0 and there is no timeout.
- The first bit sent ends in the last tile's bit BITS_PER_TILE-1.

Optional Feature:
- Macro CFG_READBACK_EN.
- When defined: adds outputs rb_data[WORD_W-1:0] and rb_valid. Each chain_tail bit sampled in SHIFT_LO is packed MSB-first. rb_valid pulses for one cycle when WORD_W bits have been collected, or at FINISH with a partial word left-aligned and zero-padded. This applies in both load and verify modes.
- When not defined: those ports do not exist and chain_tail is used only for verify.

Test Plan:
- Reset: check every output. Then start, verify=0, NUM_TILES=1, and 5 words 0xA5. Require:
  - 40 shift_clk rising edges.
  - shift_i sequence 1,0,1,0,0,1,0,1 repeated.
  - done a single pulse, shift_en falls in the same cycle.
  - A behavioural switch model ends holding data=0xA5A5A5A5A5.
- Load, then a verify pass with identical words: mismatch=0 and cfg_loaded=1. Repeat with one bit flipped in word 2: mismatch=1 and it stays set after done.
- Hold cfg_valid low for 10 cycles between words: shift_clk stays 0, busy=1, no bits lost, final chain contents correct.
- NUM_TILES=1, WORD_W=12: the 4th word is consumed for its upper 4 bits only, and cfg_ready is never asserted again.
- Assert rst after 17 bits: all outputs return to reset values immediately, shift_en=1, cfg_loaded=0. A subsequent full load succeeds.
- Pulse start during busy: no effect on counter or state. With CFG_READBACK_EN, a second load of 0x3C words yields rb_data=0x3C on each rb_valid.

Source files
------------

// File: rtl/cfg_chain_loader.sv
// Serialises configuration words MSB-first onto the switch-box shift chain and
// optionally verifies it. Define CFG_READBACK_EN to add the rb_data/rb_valid readback port.
`timescale 1ns/1ps

module cfg_chain_loader #(
    parameter int NUM_TILES     = 4,
    parameter int BITS_PER_TILE = 40,
    parameter int WORD_W        = 8,
    localparam int TOTAL_BITS   = NUM_TILES * BITS_PER_TILE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              shift_clk,
    output logic              shift_en,
    output logic              shift_i,
    input  logic              chain_tail,
    output logic              busy,
    output logic              done,
    output logic              cfg_loaded,
    output logic              mismatch
`ifdef CFG_READBACK_EN
    ,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
`endif
);

    localparam int CNT_W = $clog2(TOTAL_BITS + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, FINISH} state_t;

    state_t            state_q, state_n;
    logic              mode_q, mode_n;
    logic [WORD_W-1:0] word_q, word_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              shift_clk_q, shift_clk_n;
    logic              shift_en_q, shift_en_n;
    logic              shift_i_q, shift_i_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              loaded_q, loaded_n;
    logic              mismatch_q, mismatch_n;

`ifdef CFG_READBACK_EN
    logic [WORD_W-1:0] rb_shift_q, rb_shift_n;
    logic [WORD_W-1:0] rb_data_q, rb_data_n;
    logic [IDX_W-1:0]  rb_cnt_q, rb_cnt_n;
    logic              rb_valid_q, rb_valid_n;
`else
    // Without readback, chain_tail feeds only the verify compare.
`endif

    // Chain-facing outputs are registered from next-state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register, including the word buffer, is reset so an aborted pass leaves no stale state.
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            word_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            shift_clk_q <= 1'b0;
            shift_en_q  <= 1'b1;
            shift_i_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            loaded_q    <= 1'b0;
            mismatch_q  <= 1'b0;
`ifdef CFG_READBACK_EN
            rb_shift_q  <= '0;
            rb_data_q   <= '0;
            rb_cnt_q    <= '0;
            rb_valid_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so all state updates see pre-edge values.
            state_q     <= state_n;
            mode_q      <= mode_n;
            word_q      <= word_n;
            idx_q       <= idx_n;
            cnt_q       <= cnt_n;
            shift_clk_q <= shift_clk_n;
            shift_en_q  <= shift_en_n;
            shift_i_q   <= shift_i_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            loaded_q    <= loaded_n;
            mismatch_q  <= mismatch_n;
`ifdef CFG_READBACK_EN
            rb_shift_q  <= rb_shift_n;
            rb_data_q   <= rb_data_n;
            rb_cnt_q    <= rb_cnt_n;
            rb_valid_q  <= rb_valid_n;
`endif
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_n     = state_q;
        mode_n      = mode_q;
        word_n      = word_q;
        idx_n       = idx_q;
        cnt_n       = cnt_q;
        shift_clk_n = shift_clk_q;
        shift_en_n  = shift_en_q;
        shift_i_n   = shift_i_q;
        busy_n      = busy_q;
        done_n      = 1'b0;
        loaded_n    = loaded_q;
        mismatch_n  = mismatch_q;
`ifdef CFG_READBACK_EN
        rb_shift_n  = rb_shift_q;
        rb_data_n   = rb_data_q;
        rb_cnt_n    = rb_cnt_q;
        rb_valid_n  = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_n     = verify;
                    cnt_n      = '0;
                    if (!verify) mismatch_n = 1'b0;
                    busy_n     = 1'b1;
                    shift_en_n = 1'b1;
                    loaded_n   = 1'b0;
`ifdef CFG_READBACK_EN
                    rb_cnt_n   = '0;
`endif
                    state_n    = FETCH;
                end
            end

            FETCH: begin
                if (cfg_valid) begin
                    word_n    = cfg_data;
                    idx_n     = IDX_W'(WORD_W - 1);
                    shift_i_n = cfg_data[WORD_W-1];
                    state_n   = SHIFT_LO;
                end
            end

            SHIFT_LO: begin
                // chain_tail still holds the previous bitstream's bit here, ahead of the rising edge.
                if (mode_q && (chain_tail != word_q[idx_q])) mismatch_n = 1'b1;
`ifdef CFG_READBACK_EN
                rb_shift_n = {rb_shift_q[WORD_W-2:0], chain_tail};
                if (rb_cnt_q == IDX_W'(WORD_W - 1)) begin
                    rb_data_n  = rb_shift_n;
                    rb_valid_n = 1'b1;
                    rb_cnt_n   = '0;
                end else begin
                    rb_cnt_n   = rb_cnt_q + 1'b1;
                end
`endif
                shift_clk_n = 1'b1;
                state_n     = SHIFT_HI;
            end

            SHIFT_HI: begin
                shift_clk_n = 1'b0;
                cnt_n       = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(TOTAL_BITS - 1)) begin
                    // Leftover low bits of a partial final word are dropped here.
                    shift_en_n = 1'b0;
                    busy_n     = 1'b0;
                    done_n     = 1'b1;
                    loaded_n   = 1'b1;
`ifdef CFG_READBACK_EN
                    if (rb_cnt_q != '0) begin
                        rb_data_n  = rb_shift_q << (WORD_W - int'(rb_cnt_q));
                        rb_valid_n = 1'b1;
                    end
`endif
                    state_n    = FINISH;
                end else if (idx_q == '0) begin
                    state_n = FETCH;
                end else begin
                    idx_n     = idx_q - 1'b1;
                    shift_i_n = word_q[idx_n];
                    state_n   = SHIFT_LO;
                end
            end

            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign cfg_ready  = (state_q == FETCH);
    assign shift_clk  = shift_clk_q;
    assign shift_en   = shift_en_q;
    assign shift_i    = shift_i_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_loaded = loaded_q;
    assign mismatch   = mismatch_q;
`ifdef CFG_READBACK_EN
    assign rb_data    = rb_data_q;
    assign rb_valid   = rb_valid_q;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: table-driven passes, random passes against a
// bitstream-level model, reset abort, partial-final-word and (with CFG_READBACK_EN) readback.
`timescale 1ns/1ps

module tb_cfg_chain_loader;

    localparam int TOT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT A: 1 tile, 8-bit words ----------------
    logic       start_a = 1'b0, verify_a = 1'b0, cfg_valid_a = 1'b0;
    logic [7:0] cfg_data_a = '0;
    logic       cfg_ready_a, shift_clk_a, shift_en_a, shift_i_a, tail_a;
    logic       busy_a, done_a, cfg_loaded_a, mismatch_a;
`ifdef CFG_READBACK_EN
    logic [7:0] rb_data_a;
    logic       rb_valid_a;
    logic [11:0] rb_data_b;
    logic        rb_valid_b;
`endif

    cfg_chain_loader #(.NUM_TILES(1), .BITS_PER_TILE(40), .WORD_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .verify(verify_a),
        .cfg_data(cfg_data_a), .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
        .shift_clk(shift_clk_a), .shift_en(shift_en_a), .shift_i(shift_i_a),
        .chain_tail(tail_a), .busy(busy_a), .done(done_a),
        .cfg_loaded(cfg_loaded_a), .mismatch(mismatch_a)
`ifdef CFG_READBACK_EN
        , .rb_data(rb_data_a), .rb_valid(rb_valid_a)
`endif
    );

    // Behavioural switch chain: first bit in ends at the MSB (last tile's top bit).
    logic [TOT-1:0] chain_a = '0;
    int             edges_a = 0;
    bit             bits_a[$];
    always @(posedge shift_clk_a) begin
        chain_a <= {chain_a[TOT-2:0], shift_i_a};
        edges_a <= edges_a + 1;
        bits_a.push_back(shift_i_a);
    end
    assign tail_a = chain_a[TOT-1];

    // ---------------- DUT B: 1 tile, 12-bit words ----------------
    logic        start_b = 1'b0, verify_b = 1'b0, cfg_valid_b = 1'b0;
    logic [11:0] cfg_data_b = '0;
    logic        cfg_ready_b, shift_clk_b, shift_en_b, shift_i_b, tail_b;
    logic        busy_b, done_b, cfg_loaded_b, mismatch_b;

    cfg_chain_loader #(.NUM_TILES(1), .BITS_PER_TILE(40), .WORD_W(12)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .verify(verify_b),
        .cfg_data(cfg_data_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
        .shift_clk(shift_clk_b), .shift_en(shift_en_b), .shift_i(shift_i_b),
        .chain_tail(tail_b), .busy(busy_b), .done(done_b),
        .cfg_loaded(cfg_loaded_b), .mismatch(mismatch_b)
`ifdef CFG_READBACK_EN
        , .rb_data(rb_data_b), .rb_valid(rb_valid_b)
`endif
    );

    logic [TOT-1:0] chain_b = '0;
    int             edges_b = 0;
    always @(posedge shift_clk_b) begin
        chain_b <= {chain_b[TOT-2:0], shift_i_b};
        edges_b <= edges_b + 1;
    end
    assign tail_b = chain_b[TOT-1];

`ifdef CFG_READBACK_EN
    logic [7:0] rbq[$];
    always @(negedge clk) if (rb_valid_a) rbq.push_back(rb_data_a);
`endif

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_a();
        check("rst_shift_en",  shift_en_a, 1);
        check("rst_shift_clk", shift_clk_a, 0);
        check("rst_shift_i",   shift_i_a, 0);
        check("rst_cfg_ready", cfg_ready_a, 0);
        check("rst_busy",      busy_a, 0);
        check("rst_done",      done_a, 0);
        check("rst_loaded",    cfg_loaded_a, 0);
        check("rst_mismatch",  mismatch_a, 0);
    endtask

    logic [7:0] wq[5];

    // One complete pass on DUT A with the words in wq.
    task automatic host_pass_a(input bit vfy, input int gap, input bit poke, input bit exp_mm);
        logic [TOT-1:0] exp_chain;
        int e0, b0, n, bad;
        exp_chain = {wq[0], wq[1], wq[2], wq[3], wq[4]};
        e0 = edges_a;
        b0 = bits_a.size();
        start_a = 1'b1; verify_a = vfy;
        @(posedge clk); #1;
        start_a = 1'b0; verify_a = 1'b0;
        check("busy_at_start", busy_a, 1);
        check("shift_en_at_start", shift_en_a, 1);
        check("loaded_cleared", cfg_loaded_a, 0);
        for (int w = 0; w < 5; w++) begin
            n = 0;
            while (!cfg_ready_a && n < 100) begin @(posedge clk); #1; n++; end
            check("ready_wait", cfg_ready_a, 1);
            if (gap > 0 && w > 0) begin
                bad = 0;
                repeat (gap) begin
                    @(posedge clk); #1;
                    if (shift_clk_a !== 1'b0 || busy_a !== 1'b1 || cfg_ready_a !== 1'b1) bad++;
                end
                check("stall_hold", bad, 0);
            end
            cfg_valid_a = 1'b1; cfg_data_a = wq[w];
            @(posedge clk); #1;
            cfg_valid_a = 1'b0;
            if (poke && w == 1) begin
                start_a = 1'b1; verify_a = 1'b1;
                @(posedge clk); #1;
                start_a = 1'b0; verify_a = 1'b0;
                check("busy_after_poke", busy_a, 1);
            end
        end
        n = 0;
        while (!done_a && n < 300) begin @(posedge clk); #1; n++; end
        check("done_seen", done_a, 1);
        check("shift_en_with_done", shift_en_a, 0);
        check("busy_with_done", busy_a, 0);
        check("loaded_with_done", cfg_loaded_a, 1);
        check("mismatch_at_done", mismatch_a, exp_mm);
        @(posedge clk); #1;
        check("done_one_cycle", done_a, 0);
        check("mismatch_sticky", mismatch_a, exp_mm);
        check("loaded_held", cfg_loaded_a, 1);
        check("edge_count", edges_a - e0, TOT);
        bad = 0;
        for (int k = 0; k < TOT; k++)
            if (b0 + k >= bits_a.size() || bits_a[b0 + k] != exp_chain[TOT-1-k]) bad++;
        check("shift_i_seq", bad, 0);
        check("chain_contents", chain_a, exp_chain);
    endtask

    typedef struct {
        bit         vfy;
        logic [7:0] base;
        int         flip_w;
        int         flip_b;
        int         gap;
        bit         poke;
        bit         exp_mm;
    } vec_t;

    vec_t           vecs[6];
    logic [TOT-1:0] prev_chain;
    logic [TOT-1:0] new_chain;
    bit             mm_model;
    bit             vfy_r;
    bit             exp_r;
    int             e0, n, bad;
    logic [11:0]    wb[5];

    initial begin
        vecs[0] = '{1'b0, 8'hA5, -1, 0, 0,  1'b0, 1'b0};  // plain load
        vecs[1] = '{1'b1, 8'hA5, -1, 0, 0,  1'b0, 1'b0};  // verify, identical
        vecs[2] = '{1'b1, 8'hA5,  2, 3, 0,  1'b0, 1'b1};  // verify, word 2 bit 3 flipped
        vecs[3] = '{1'b0, 8'h5A, -1, 0, 10, 1'b0, 1'b0};  // load with host stalls, clears mismatch
        vecs[4] = '{1'b0, 8'hC3, -1, 0, 0,  1'b1, 1'b0};  // start pulsed mid-pass
        vecs[5] = '{1'b1, 8'hC3, -1, 0, 0,  1'b0, 1'b0};  // verify after poked load

        repeat (2) @(posedge clk); #1;
        check_reset_a();
        check("rst_b_shift_en", shift_en_b, 1);
        check("rst_b_cfg_ready", cfg_ready_b, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            for (int w = 0; w < 5; w++) wq[w] = vecs[i].base;
            if (vecs[i].flip_w >= 0) wq[vecs[i].flip_w][vecs[i].flip_b] = ~wq[vecs[i].flip_w][vecs[i].flip_b];
            host_pass_a(vecs[i].vfy, vecs[i].gap, vecs[i].poke, vecs[i].exp_mm);
            mm_model = vecs[i].exp_mm;
        end
        prev_chain = {wq[0], wq[1], wq[2], wq[3], wq[4]};

        // Random passes: a verify re-sends the previous words, sometimes with one bit corrupted.
        for (int r = 0; r < 8; r++) begin
            vfy_r = 1'($urandom_range(0, 1));
            if (vfy_r) begin
                if ($urandom_range(0, 1) == 1) begin
                    n = int'($urandom_range(0, 4));
                    bad = int'($urandom_range(0, 7));
                    wq[n][bad] = ~wq[n][bad];
                end
            end else begin
                for (int w = 0; w < 5; w++) wq[w] = 8'($urandom);
            end
            new_chain = {wq[0], wq[1], wq[2], wq[3], wq[4]};
            exp_r = vfy_r ? (mm_model || (new_chain != prev_chain)) : 1'b0;
            host_pass_a(vfy_r, 0, 0, exp_r);
            mm_model = exp_r;
            prev_chain = new_chain;
        end

        // Reset in the middle of a pass after 17 bits.
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cfg_valid_a = 1'b1; cfg_data_a = 8'hA5;
        e0 = edges_a; n = 0;
        while (edges_a - e0 < 17 && n < 500) begin @(posedge clk); #1; n++; end
        check("bits_before_rst", edges_a - e0, 17);
        #2 rst = 1'b1;
        #1;
        check_reset_a();
        cfg_valid_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", busy_a, 0);
        wq = '{8'h0F, 8'h81, 8'h7E, 8'h33, 8'hE4};
        host_pass_a(1'b0, 0, 1'b0, 1'b0);

        // 12-bit words over a 40-bit chain: only the top 4 bits of word 4 are used.
        wb = '{12'hABC, 12'h123, 12'h456, 12'h789, 12'hFFF};
        e0 = edges_b;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int w = 0; w < 4; w++) begin
            n = 0;
            while (!cfg_ready_b && n < 100) begin @(posedge clk); #1; n++; end
            check("b_ready_wait", cfg_ready_b, 1);
            cfg_valid_b = 1'b1; cfg_data_b = wb[w];
            @(posedge clk); #1;
            cfg_valid_b = 1'b0;
        end
        cfg_valid_b = 1'b1; cfg_data_b = wb[4];
        n = 0; bad = 0;
        while (!done_b && n < 300) begin
            if (cfg_ready_b) bad++;
            @(posedge clk); #1; n++;
        end
        check("b_done_seen", done_b, 1);
        check("b_no_fifth_ready", bad, 0);
        check("b_chain", chain_b, 40'hABC1234567);
        check("b_edges", edges_b - e0, TOT);
        @(posedge clk); #1;
        check("b_ready_after", cfg_ready_b, 0);
        check("b_loaded", cfg_loaded_b, 1);
        cfg_valid_b = 1'b0;

`ifdef CFG_READBACK_EN
        for (int w = 0; w < 5; w++) wq[w] = 8'h3C;
        host_pass_a(1'b0, 0, 1'b0, 1'b0);
        n = rbq.size();
        host_pass_a(1'b0, 0, 1'b0, 1'b0);
        check("rb_count", rbq.size() - n, 5);
        bad = 0;
        for (int k = n; k < rbq.size(); k++) if (rbq[k] != 8'h3C) bad++;
        check("rb_data", bad, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
